// File: rtl/ram_access_ctrl_if.sv
// Request/response handshake plus RAM pin bundle between the requester, the
// sequencing controller and the 4-byte RAM.
interface ram_access_ctrl_if;
   logic       reqValid;
   logic       reqReady;
   logic [1:0] reqOp;
   logic [1:0] reqAddr;
   logic [7:0] reqData;
   logic       rspValid;
   logic       rspReady;
   logic [7:0] rspData;
   logic [7:0] ramData;
   logic [1:0] ramSel;
   logic       ramRead;
   logic       ramClearN;
   logic [7:0] ramQ;

   modport slave (
      input  reqValid, reqOp, reqAddr, reqData, rspReady, ramQ,
      output reqReady, rspValid, rspData, ramData, ramSel, ramRead, ramClearN
   );

   modport master (
      output reqValid, reqOp, reqAddr, reqData, rspReady, ramQ,
      input  reqReady, rspValid, rspData, ramData, ramSel, ramRead, ramClearN
   );
endinterface

// File: rtl/ram_access_ctrl.sv
// Sequences read/write/clear requests onto the 4-byte RAM pins with fixed
// setup/strobe/hold windows; clears the RAM after every reset.
module ram_access_ctrl #(
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 1,
   parameter int HOLD_CYC   = 1,
   parameter int CLR_CYC    = 2
) (
   input logic              clk_i,
   input logic              rst_ni,
   ram_access_ctrl_if.slave bus
);

   localparam int MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
   localparam int MAX_HC  = (HOLD_CYC > CLR_CYC) ? HOLD_CYC : CLR_CYC;
   localparam int MAX_CYC = (MAX_SS > MAX_HC) ? MAX_SS : MAX_HC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LD    = CNT_W'(CLR_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;

   typedef enum logic [2:0] {
      INIT, IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_RESP, CLR
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             reqReady_q;
   logic             rspValid_q;
   logic [7:0]       rspData_q;
   logic [7:0]       ramData_q;
   logic [1:0]       ramSel_q;
   logic             ramRead_q;
   logic             ramClearN_q;

   // Counter is loaded with (cycles-1) on each state entry and the state
   // advances on the edge where it has reached zero.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= INIT;
         cnt_q       <= '0;
         reqReady_q  <= 1'b0;
         rspValid_q  <= 1'b0;
         rspData_q   <= 8'h00;
         ramData_q   <= 8'h00;
         ramSel_q    <= 2'b00;
         ramRead_q   <= 1'b1;
         ramClearN_q <= 1'b1;
      end else begin
         case (state_q)
            INIT: begin
               // First edge out of reset starts the clear pulse
               if (ramClearN_q) begin
                  ramClearN_q <= 1'b0;
                  cnt_q       <= CLR_LD;
               end else if (cnt_q == '0) begin
                  ramClearN_q <= 1'b1;
                  reqReady_q  <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            IDLE: begin
               if (bus.reqValid && reqReady_q) begin
                  case (bus.reqOp)
                     OP_READ: begin
                        ramSel_q   <= bus.reqAddr;
                        cnt_q      <= SETUP_LD;
                        reqReady_q <= 1'b0;
                        state_q    <= R_SETUP;
                     end
                     OP_WRITE: begin
                        ramSel_q   <= bus.reqAddr;
                        ramData_q  <= bus.reqData;
                        cnt_q      <= SETUP_LD;
                        reqReady_q <= 1'b0;
                        state_q    <= W_SETUP;
                     end
                     OP_CLEAR: begin
                        ramClearN_q <= 1'b0;
                        cnt_q       <= CLR_LD;
                        reqReady_q  <= 1'b0;
                        state_q     <= CLR;
                     end
                     default: ;
                  endcase
               end
            end
            W_SETUP: begin
               if (cnt_q == '0) begin
                  ramRead_q <= 1'b0;
                  cnt_q     <= STROBE_LD;
                  state_q   <= W_STROBE;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            W_STROBE: begin
               if (cnt_q == '0) begin
                  ramRead_q <= 1'b1;
                  cnt_q     <= HOLD_LD;
                  state_q   <= W_HOLD;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            W_HOLD: begin
               if (cnt_q == '0) begin
                  reqReady_q <= 1'b1;
                  state_q    <= IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            R_SETUP: begin
               if (cnt_q == '0) begin
                  rspData_q  <= bus.ramQ;
                  rspValid_q <= 1'b1;
                  state_q    <= R_RESP;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            R_RESP: begin
               if (bus.rspReady) begin
                  rspValid_q <= 1'b0;
                  reqReady_q <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            CLR: begin
               if (cnt_q == '0) begin
                  ramClearN_q <= 1'b1;
                  reqReady_q  <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
         endcase
      end
   end

   assign bus.reqReady  = reqReady_q;
   assign bus.rspValid  = rspValid_q;
   assign bus.rspData   = rspData_q;
   assign bus.ramData   = ramData_q;
   assign bus.ramSel    = ramSel_q;
   assign bus.ramRead   = ramRead_q;
   assign bus.ramClearN = ramClearN_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural 4-byte RAM attached
// to the controller's RAM pins.
module tb_ram_access_ctrl;

   logic clk;
   logic rstN;
   int   checks;
   int   failures;
   int   n;
   int   lowCnt;
   logic [7:0] rd;
   logic [7:0] mem [4];

   ram_access_ctrl_if bus ();

   ram_access_ctrl dut (
      .clk_i  (clk),
      .rst_ni (rstN),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM: clear dominates, write on edges sampled with Read low
   always @(posedge clk) begin
      if (!bus.ramClearN) begin
         for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
      end else if (!bus.ramRead) begin
         mem[bus.ramSel] <= bus.ramData;
      end
   end
   assign bus.ramQ = mem[bus.ramSel];

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitReady();
      int k = 0;
      while (!bus.reqReady && k < 50) begin
         @(negedge clk);
         k++;
      end
      checkOutput("req_ready_wait", 8'(bus.reqReady), 8'd1);
   endtask

   // Presents one request and returns at the negedge after its acceptance edge
   task automatic applyStimulus(input logic [1:0] op, input logic [1:0] addr,
                                input logic [7:0] data);
      waitReady();
      bus.reqValid = 1'b1;
      bus.reqOp    = op;
      bus.reqAddr  = addr;
      bus.reqData  = data;
      @(negedge clk);
      bus.reqValid = 1'b0;
   endtask

   task automatic doWrite(input logic [1:0] addr, input logic [7:0] data);
      int k = 0;
      applyStimulus(2'b01, addr, data);
      while (!bus.reqReady && k < 20) begin
         @(negedge clk);
         k++;
      end
      checkOutput("write_busy_cycles", 8'(k), 8'd3);
   endtask

   task automatic doRead(input logic [1:0] addr, output logic [7:0] data);
      int k = 0;
      applyStimulus(2'b00, addr, 8'h00);
      while (!bus.rspValid && k < 20) begin
         @(negedge clk);
         k++;
      end
      checkOutput("rsp_valid_wait", 8'(bus.rspValid), 8'd1);
      data = bus.rspData;
      bus.rspReady = 1'b1;
      @(negedge clk);
      bus.rspReady = 1'b0;
      checkOutput("rsp_valid_drop", 8'(bus.rspValid), 8'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before summary");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      checks       = 0;
      failures     = 0;
      rstN         = 1'b0;
      bus.reqValid = 1'b0;
      bus.reqOp    = 2'b11;
      bus.reqAddr  = 2'b00;
      bus.reqData  = 8'h00;
      bus.rspReady = 1'b0;
      repeat (3) @(negedge clk);

      checkOutput("rst_req_ready", 8'(bus.reqReady), 8'd0);
      checkOutput("rst_clear_n", 8'(bus.ramClearN), 8'd1);
      checkOutput("rst_ram_read", 8'(bus.ramRead), 8'd1);
      checkOutput("rst_rsp_valid", 8'(bus.rspValid), 8'd0);
      checkOutput("rst_ram_sel", 8'(bus.ramSel), 8'd0);
      checkOutput("rst_ram_data", bus.ramData, 8'h00);
      checkOutput("rst_rsp_data", bus.rspData, 8'h00);

      // Post-reset clear pulse and ready timing
      rstN   = 1'b1;
      n      = 0;
      lowCnt = 0;
      while (!bus.reqReady && n < 20) begin
         @(negedge clk);
         n++;
         if (!bus.ramClearN) lowCnt++;
      end
      checkOutput("init_clear_cycles", 8'(lowCnt), 8'd2);
      checkOutput("init_ready_delay", 8'(n), 8'd3);
      checkOutput("init_clear_released", 8'(bus.ramClearN), 8'd1);
      for (int a = 0; a < 4; a++) begin
         doRead(2'(a), rd);
         checkOutput("init_read_zero", rd, 8'h00);
      end

      // Write 0xA5 to address 2 with per-cycle pin checks
      applyStimulus(2'b01, 2'd2, 8'hA5);
      checkOutput("w_e0_sel", 8'(bus.ramSel), 8'd2);
      checkOutput("w_e0_data", bus.ramData, 8'hA5);
      checkOutput("w_e0_read", 8'(bus.ramRead), 8'd1);
      checkOutput("w_e0_ready", 8'(bus.reqReady), 8'd0);
      @(negedge clk);
      checkOutput("w_e1_strobe", 8'(bus.ramRead), 8'd0);
      checkOutput("w_e1_sel", 8'(bus.ramSel), 8'd2);
      checkOutput("w_e1_data", bus.ramData, 8'hA5);
      checkOutput("w_e1_clear_n", 8'(bus.ramClearN), 8'd1);
      @(negedge clk);
      checkOutput("w_e2_read", 8'(bus.ramRead), 8'd1);
      checkOutput("w_e2_ready", 8'(bus.reqReady), 8'd0);
      @(negedge clk);
      checkOutput("w_e3_ready", 8'(bus.reqReady), 8'd1);
      checkOutput("w_e3_sel", 8'(bus.ramSel), 8'd2);
      checkOutput("w_e3_data", bus.ramData, 8'hA5);

      // Read back address 2 with exact response timing
      applyStimulus(2'b00, 2'd2, 8'h00);
      checkOutput("r_e0_rsp_valid", 8'(bus.rspValid), 8'd0);
      @(negedge clk);
      checkOutput("r_e1_rsp_valid", 8'(bus.rspValid), 8'd1);
      checkOutput("r_e1_rsp_data", bus.rspData, 8'hA5);
      bus.rspReady = 1'b1;
      @(negedge clk);
      bus.rspReady = 1'b0;
      checkOutput("r_e2_rsp_valid", 8'(bus.rspValid), 8'd0);
      checkOutput("r_e2_req_ready", 8'(bus.reqReady), 8'd1);

      // Fill all words, read back out of order
      doWrite(2'd0, 8'h11);
      doWrite(2'd1, 8'h22);
      doWrite(2'd2, 8'h33);
      doWrite(2'd3, 8'h44);
      doRead(2'd3, rd); checkOutput("fill_read_3", rd, 8'h44);
      doRead(2'd0, rd); checkOutput("fill_read_0", rd, 8'h11);
      doRead(2'd1, rd); checkOutput("fill_read_1", rd, 8'h22);
      doRead(2'd2, rd); checkOutput("fill_read_2", rd, 8'h33);

      // No-op is swallowed without leaving IDLE or touching the pins
      applyStimulus(2'b11, 2'd3, 8'hFF);
      checkOutput("noop_ready", 8'(bus.reqReady), 8'd1);
      checkOutput("noop_sel", 8'(bus.ramSel), 8'd2);
      checkOutput("noop_data", bus.ramData, 8'h44);

      // Back-pressured read; a write held meanwhile must be ignored
      applyStimulus(2'b00, 2'd1, 8'h00);
      @(negedge clk);
      bus.reqValid = 1'b1;
      bus.reqOp    = 2'b01;
      bus.reqAddr  = 2'd1;
      bus.reqData  = 8'h99;
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_rsp_valid", 8'(bus.rspValid), 8'd1);
         checkOutput("bp_rsp_data", bus.rspData, 8'h22);
         checkOutput("bp_req_ready", 8'(bus.reqReady), 8'd0);
         @(negedge clk);
      end
      bus.reqValid = 1'b0;
      checkOutput("bp_still_valid", 8'(bus.rspValid), 8'd1);
      bus.rspReady = 1'b1;
      @(negedge clk);
      bus.rspReady = 1'b0;
      checkOutput("bp_released", 8'(bus.rspValid), 8'd0);
      doRead(2'd1, rd);
      checkOutput("bp_write_ignored", rd, 8'h22);

      // Clear op: two-cycle pulse, select untouched
      applyStimulus(2'b10, 2'd3, 8'h00);
      checkOutput("clr_e0_sel", 8'(bus.ramSel), 8'd1);
      checkOutput("clr_e0_ready", 8'(bus.reqReady), 8'd0);
      lowCnt = (bus.ramClearN == 1'b0) ? 1 : 0;
      n = 0;
      while (!bus.reqReady && n < 20) begin
         @(negedge clk);
         n++;
         if (!bus.ramClearN) lowCnt++;
      end
      checkOutput("clr_low_cycles", 8'(lowCnt), 8'd2);
      checkOutput("clr_sel_kept", 8'(bus.ramSel), 8'd1);
      checkOutput("clr_ram_read", 8'(bus.ramRead), 8'd1);
      doRead(2'd0, rd); checkOutput("clr_read_0", rd, 8'h00);
      doRead(2'd3, rd); checkOutput("clr_read_3", rd, 8'h00);

      // Reset in the middle of a write strobe
      doWrite(2'd0, 8'h77);
      doRead(2'd0, rd);
      checkOutput("pre_rst_read_0", rd, 8'h77);
      applyStimulus(2'b01, 2'd0, 8'h5A);
      @(negedge clk);
      checkOutput("mid_strobe_low", 8'(bus.ramRead), 8'd0);
      rstN = 1'b0;
      @(negedge clk);
      checkOutput("mid_rst_ram_read", 8'(bus.ramRead), 8'd1);
      checkOutput("mid_rst_rsp_valid", 8'(bus.rspValid), 8'd0);
      checkOutput("mid_rst_req_ready", 8'(bus.reqReady), 8'd0);
      checkOutput("mid_rst_clear_n", 8'(bus.ramClearN), 8'd1);
      rstN = 1'b1;
      waitReady();
      doRead(2'd0, rd);
      checkOutput("post_rst_read_0", rd, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
